clkrst_seq: RTL and testbench
=============================

CLKRST_SEQ -- requirements
Module: clkrst_seq

Interface
REQ-001 SHALL have parameter DOMAINS, default 3, meaning number of reset domains sequenced (1-8).
REQ-002 SHALL have parameter LOCKS, default 3, meaning number of lock inputs monitored (1-8).
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16, meaning pll_rst assertion length in cycles (>=2).
REQ-004 SHALL have parameter LOCK_FILTER, default 64, meaning consecutive all-locked cycles required before release.
REQ-005 SHALL have parameter STAGGER, default 8, meaning cycles between successive domain reset releases (>=1).
REQ-006 SHALL have parameter LOCK_TIMEOUT, default 65535, meaning maximum WAIT_LOCK cycles before PLL retry.
REQ-007 SHALL have ports: clk  in  1  free-running reference clock; rst_n  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: locked_in  in  LOCKS  asynchronous lock indicators; force_rst  in  1  synchronous request to restart sequencing.
REQ-009 SHALL have ports: pll_rst  out  1  PLL reset; rst_out  out  DOMAINS  per-domain reset, active-high; ready  out  1  all domains released.
REQ-010 SHALL have ports: lock_lost  out  1  one-cycle pulse on lock loss in RUN; timeout_err  out  1  one-cycle pulse on lock timeout; retry_count  out  8  PLL retry count.

Function
REQ-011 SHALL synchronise each locked_in bit through two flops; "all_locked" = AND of synchronised bits, 2-cycle latency.
REQ-012 SHALL implement FSM states PLL_RST, WAIT_LOCK, FILTER, RELEASE, RUN.
REQ-013 PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
REQ-014 WAIT_LOCK: all_locked -> FILTER; timer reaching LOCK_TIMEOUT -> PLL_RST, timeout_err pulse, retry_count+1.
REQ-015 retry_count SHALL saturate at 255, never wrap, and clear only on rst_n.
REQ-016 FILTER: all_locked high for LOCK_FILTER consecutive cycles -> RELEASE; any low cycle -> WAIT_LOCK with timeout timer cleared.
REQ-017 RELEASE: rst_out[0] deasserts on first RELEASE cycle; rst_out[i] deasserts STAGGER cycles after rst_out[i-1]; RUN entered STAGGER cycles after rst_out[DOMAINS-1].
REQ-018 RUN: ready=1, all rst_out=0, pll_rst=0.
REQ-019 Any all_locked low in RELEASE or RUN SHALL, next cycle: assert all rst_out, clear ready, enter PLL_RST; lock_lost pulses only when leaving RUN.
REQ-020 force_rst=1 in any state SHALL have the same effect as REQ-019, with no lock_lost pulse and retry_count unchanged; force_rst has priority over lock loss.
REQ-021 rst_out SHALL be 1 in PLL_RST, WAIT_LOCK, FILTER; released bits never re-deassert out of order.
REQ-022 Counters SHALL be sized from $clog2 of the largest parameter and never wrap within a state.

Reset
REQ-023 On rst_n=0 at a clk edge: state=PLL_RST, all counters 0, pll_rst=1, rst_out all 1, ready=0, lock_lost=0, timeout_err=0, retry_count=0, synchroniser flops 0.
REQ-024 rst_n mid-sequence SHALL abort immediately to REQ-023 values with no partial release.

Structure
REQ-025 State enum and a counter-width constant function SHALL live in shared package clkrst_pkg.
REQ-026 The two-flop synchroniser SHALL be a sub-module, sync_2ff, instantiated LOCKS times.

Verification (DOMAINS=3, LOCKS=2, PLL_RST_CYCLES=4, LOCK_FILTER=8, STAGGER=2, LOCK_TIMEOUT=100)
REQ-027 Locks held high, rst_n released -> pll_rst high 4 cycles; rst_out[0..2] fall at 2-cycle spacing; ready rises 2 cycles after rst_out[2] falls.
REQ-028 Locks low 250 cycles -> timeout_err pulses twice, retry_count=2, pll_rst reasserted 4 cycles after each timeout.
REQ-029 In RUN, drop locked_in[1] 1 cycle -> lock_lost 1-cycle pulse 3 cycles later, all rst_out=1, ready=0, full sequence repeats.
REQ-030 Lock glitches low at FILTER count 5 -> back to WAIT_LOCK; release only after a further 8 clean cycles.
REQ-031 force_rst during RELEASE after rst_out[0] falls -> all rst_out=1 next cycle, lock_lost=0, retry_count unchanged.
REQ-032 Run 300 timeouts -> retry_count holds at 255.

Source files
------------

// File: rtl/clkrst_pkg.sv
// Shared definitions for the clock/reset sequencer: FSM state encoding,
// retry counter geometry and a helper that sizes the sequencing counter.
package clkrst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int                 RETRY_W   = 8;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width needed for a counter that must hold the largest of four limits
  // without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = max2(max2(a, b), max2(c, d));
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level signal into the clk
// domain. Output lags the input by two clk edges.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the asynchronous input through the two synchroniser stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so each flop samples its pre-edge input; with
    // blocking assignments the two stages would collapse into one.
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clkrst_seq.sv
// Clock/reset sequencer: pulses the PLL reset, waits for (filtered) lock on
// all monitored clocks, then releases the domain resets one by one with a
// fixed stagger. Lock loss or force_rst collapses everything back to
// PLL_RST; lock timeouts retry the PLL and are counted (saturating).
module clkrst_seq
  import clkrst_pkg::*;
#(
  parameter int DOMAINS        = 3,
  parameter int LOCKS          = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 64,
  parameter int STAGGER        = 8,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LOCKS-1:0]   locked_in,
  input  logic               force_rst,
  output logic               pll_rst,
  output logic [DOMAINS-1:0] rst_out,
  output logic               ready,
  output logic               lock_lost,
  output logic               timeout_err,
  output logic [7:0]         retry_count
);

  localparam int REL_LEN = DOMAINS * STAGGER;
  localparam int CW      = cnt_width(PLL_RST_CYCLES, LOCK_FILTER, REL_LEN, LOCK_TIMEOUT);

  // Terminal counts: each state leaves when its counter sits on the last value.
  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(REL_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // ---------------------------------------------------------------------
  // Lock synchronisation
  // ---------------------------------------------------------------------
  logic [LOCKS-1:0] locked_sync;
  logic             all_locked;

  for (genvar g = 0; g < LOCKS; g++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (locked_in[g]),
      .q     (locked_sync[g])
    );
  end

  assign all_locked = &locked_sync;

  // ---------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pll_rst_q, pll_rst_d;
  logic [DOMAINS-1:0]   rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 timeout_err_q, timeout_err_d;

  // Next-state, counter, retry and event-pulse logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    lock_lost_d   = 1'b0;
    timeout_err_d = 1'b0;

    if (force_rst) begin
      // Restart from scratch; not a fault, so no lock_lost and no retry.
      state_d = ST_PLL_RST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          if (all_locked) begin
            // This cycle is the first of the consecutive locked cycles.
            if (LOCK_FILTER <= 1) begin
              state_d = ST_RELEASE;
              cnt_d   = '0;
            end else begin
              state_d = ST_FILTER;
              cnt_d   = CNT_ONE;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_d       = ST_PLL_RST;
            cnt_d         = '0;
            timeout_err_d = 1'b1;
            if (retry_q != RETRY_MAX) begin
              retry_d = retry_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_FILTER: begin
          if (!all_locked) begin
            // Lock bounced: restart the wait with a fresh timeout window.
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == FILT_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RELEASE: begin
          if (!all_locked) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
          end else if (cnt_q == REL_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RUN: begin
          if (!all_locked) begin
            state_d     = ST_PLL_RST;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the outputs come straight from
  // flops (glitch-free resets) yet change in the same cycle as the state.
  always_comb begin
    pll_rst_d = (state_d == ST_PLL_RST);
    ready_d   = (state_d == ST_RUN);
    rst_out_d = '1;
    for (int i = 0; i < DOMAINS; i++) begin
      // Domain i is released once the release counter passes its slot; all
      // bits reassert together whenever RELEASE/RUN is left.
      rst_out_d[i] = !((state_d == ST_RUN) ||
                       ((state_d == ST_RELEASE) && (cnt_d >= CW'(i * STAGGER))));
    end
  end

  // Sequencer registers; rst_n forces the safe PLL_RST picture at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      rst_out_q     <= '1;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      rst_out_q     <= rst_out_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_out     = rst_out_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign timeout_err = timeout_err_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_clkrst_seq.sv
// Self-checking bench for clkrst_seq with DOMAINS=3, LOCKS=2,
// PLL_RST_CYCLES=4, LOCK_FILTER=8, STAGGER=2, LOCK_TIMEOUT=100.
module tb_clkrst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] locked_in;
  logic       force_rst;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
  logic       lock_lost;
  logic       timeout_err;
  logic [7:0] retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  clkrst_seq #(
    .DOMAINS        (3),
    .LOCKS          (2),
    .PLL_RST_CYCLES (4),
    .LOCK_FILTER    (8),
    .STAGGER        (2),
    .LOCK_TIMEOUT   (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .locked_in   (locked_in),
    .force_rst   (force_rst),
    .pll_rst     (pll_rst),
    .rst_out     (rst_out),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .timeout_err (timeout_err),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  // Per-cycle vector: inputs applied before an edge, outputs expected after.
  // exp packs {pll_rst, rst_out[2:0], ready, lock_lost}.
  typedef struct {
    logic [1:0] locked;
    logic       frc;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [5:0] obs();
    return {pll_rst, rst_out, ready, lock_lost};
  endfunction

  // Expected outputs k edges after entering PLL_RST with locks stable high.
  function automatic logic [5:0] exp_seq(input int k);
    logic       p;
    logic [2:0] r;
    logic       rd;
    p  = (k < 4);
    r  = (k < 12) ? 3'b111 : (k < 14) ? 3'b110 : (k < 16) ? 3'b100 : 3'b000;
    rd = (k >= 18);
    return {p, r, rd, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tmo_total;
    int first_tmo;
    int second_tmo;
    int ll_total;

    // Startup with locks high, then a one-cycle drop of locked_in[1] in RUN.
    vecs[0]  = '{2'b11, 1'b0, 6'b111100};
    vecs[1]  = '{2'b11, 1'b0, 6'b111100};
    vecs[2]  = '{2'b11, 1'b0, 6'b111100};
    vecs[3]  = '{2'b11, 1'b0, 6'b011100};
    vecs[4]  = '{2'b11, 1'b0, 6'b011100};
    vecs[5]  = '{2'b11, 1'b0, 6'b011100};
    vecs[6]  = '{2'b11, 1'b0, 6'b011100};
    vecs[7]  = '{2'b11, 1'b0, 6'b011100};
    vecs[8]  = '{2'b11, 1'b0, 6'b011100};
    vecs[9]  = '{2'b11, 1'b0, 6'b011100};
    vecs[10] = '{2'b11, 1'b0, 6'b011100};
    vecs[11] = '{2'b11, 1'b0, 6'b011000};
    vecs[12] = '{2'b11, 1'b0, 6'b011000};
    vecs[13] = '{2'b11, 1'b0, 6'b010000};
    vecs[14] = '{2'b11, 1'b0, 6'b010000};
    vecs[15] = '{2'b11, 1'b0, 6'b000000};
    vecs[16] = '{2'b11, 1'b0, 6'b000000};
    vecs[17] = '{2'b11, 1'b0, 6'b000010};
    vecs[18] = '{2'b11, 1'b0, 6'b000010};
    vecs[19] = '{2'b01, 1'b0, 6'b000010};
    vecs[20] = '{2'b11, 1'b0, 6'b000010};
    vecs[21] = '{2'b11, 1'b0, 6'b111101};
    vecs[22] = '{2'b11, 1'b0, 6'b111100};

    // Reset state
    rst_n     = 1'b0;
    locked_in = 2'b11;
    force_rst = 1'b0;
    repeat (3) step();
    check("reset_outputs", 32'(obs()), 32'h3C);
    check("reset_timeout_err", 32'(timeout_err), 32'h0);
    check("reset_retry", 32'(retry_count), 32'h0);

    // Table-driven startup and lock-loss entry
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      locked_in = vecs[i].locked;
      force_rst = vecs[i].frc;
      step();
      check($sformatf("vec[%0d]", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Full sequence repeats after the lock loss
    for (int k = 2; k <= 19; k++) begin
      step();
      check($sformatf("relock k=%0d", k), 32'(obs()), 32'(exp_seq(k)));
    end

    // force_rst from RUN: no lock_lost
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    check("force_from_run", 32'(obs()), 32'(exp_seq(0)));
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("pre_force k=%0d", k), 32'(obs()), 32'(exp_seq(k)));
    end

    // force_rst during RELEASE with rst_out[0] already released
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    check("force_in_release", 32'(obs()), 32'h3C);
    check("force_retry_unchanged", 32'(retry_count), 32'h0);

    // Lock glitch while FILTER count is 5: release delayed by 6 edges
    for (int k = 1; k <= 24; k++) begin
      locked_in = (k == 8) ? 2'b10 : 2'b11;
      step();
      check($sformatf("glitch k=%0d", k), 32'(obs()), 32'(k <= 9 ? exp_seq(k) : exp_seq(k - 6)));
    end

    // rst_n in RUN aborts straight to the reset picture
    locked_in = 2'b00;
    rst_n     = 1'b0;
    step();
    check("abort_outputs", 32'(obs()), 32'h3C);
    rst_n = 1'b1;

    // Locks low for 250 cycles: two timeouts
    tmo_total  = 0;
    first_tmo  = 0;
    second_tmo = 0;
    ll_total   = 0;
    for (int e = 1; e <= 250; e++) begin
      step();
      if (timeout_err) begin
        tmo_total++;
        if (tmo_total == 1) first_tmo = e;
        else if (tmo_total == 2) second_tmo = e;
      end
      if (lock_lost) ll_total++;
      if (e == 103 || e == 108 || e == 212) check($sformatf("pll_low e=%0d", e), 32'(pll_rst), 32'h0);
      if (e == 104 || e == 107 || e == 211) check($sformatf("pll_high e=%0d", e), 32'(pll_rst), 32'h1);
      if (e == 105) check("rst_out_in_pll_rst", 32'(rst_out), 32'h7);
    end
    check("timeout_pulses_250", 32'(tmo_total), 32'd2);
    check("first_timeout_edge", 32'(first_tmo), 32'd104);
    check("second_timeout_edge", 32'(second_tmo), 32'd208);
    check("retry_after_250", 32'(retry_count), 32'd2);

    // Keep timing out until 300 timeouts: retry_count saturates at 255
    for (int e = 251; e <= 32000 && tmo_total < 300; e++) begin
      step();
      if (timeout_err) begin
        tmo_total++;
        if (tmo_total == 255) check("retry_at_255th", 32'(retry_count), 32'd255);
      end
      if (lock_lost) ll_total++;
    end
    check("timeouts_reached_300", 32'(tmo_total), 32'd300);
    check("retry_saturated", 32'(retry_count), 32'd255);
    check("no_lock_lost_in_timeouts", 32'(ll_total), 32'd0);

    // Only rst_n clears retry_count
    rst_n = 1'b0;
    step();
    check("retry_cleared_by_rst", 32'(retry_count), 32'd0);
    check("final_reset_outputs", 32'(obs()), 32'h3C);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
